// File: rtl/shift_reg_univ_pkg.sv
// shift_reg_univ_pkg: mode encoding and fill-counter width helper for shift_reg_univ.
package shift_reg_univ_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;
  function automatic int fill_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one storage bit with hold/shift-right/shift-left/load mux and sync clear.
// Active edge is falling when SHIFT_REG_UNIV_NEGEDGE_EN is defined, rising otherwise.
module usr_bit_cell
  import shift_reg_univ_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  mode_t sel,
  input  logic  shr_bit,
  input  logic  shl_bit,
  input  logic  ld_bit,
  output logic  q
);
  logic d;
  always_comb begin
    d = clr ? 1'b0 :
        sel == MODE_SHR  ? shr_bit :
        sel == MODE_SHL  ? shl_bit :
        sel == MODE_LOAD ? ld_bit  : q;
  end
`ifdef SHIFT_REG_UNIV_NEGEDGE_EN
  always_ff @(negedge clk or negedge rst_n) begin
`else
  always_ff @(posedge clk or negedge rst_n) begin
`endif
    if (!rst_n) q <= 1'b0;
    else q <= d;
  end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with optional rotate, sync clear and saturating fill count.
// Define SHIFT_REG_UNIV_NEGEDGE_EN to make every register update on the falling clock edge.
module shift_reg_univ
  import shift_reg_univ_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROTATE = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  mode_t                       mode,
  input  logic                        sin,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            q,
  output logic                        sout,
  output logic [fill_w(WIDTH)-1:0]    fill,
  output logic                        full
);
  localparam int FW = fill_w(WIDTH);
  mode_t            op;
  logic             shr_in, shl_in, sout_nx;
  logic [WIDTH-1:0] shr_v, shl_v;
  logic [FW-1:0]    fill_nx;
  assign op     = en ? mode : MODE_HOLD;
  assign shr_in = ROTATE != 0 ? q[0] : sin;
  assign shl_in = ROTATE != 0 ? q[WIDTH-1] : sin;
  assign shr_v  = {shr_in, q[WIDTH-1:1]};
  assign shl_v  = {q[WIDTH-2:0], shl_in};
  assign full   = fill == FW'(WIDTH);
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    usr_bit_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .sel     (op),
      .shr_bit (shr_v[i]),
      .shl_bit (shl_v[i]),
      .ld_bit  (din[i]),
      .q       (q[i])
    );
  end
  // Fill saturates at WIDTH; sout captures whichever bit leaves the register.
  always_comb begin
    fill_nx = clr ? '0 :
              op == MODE_LOAD ? FW'(WIDTH) :
              (op == MODE_SHR || op == MODE_SHL) && !full ? fill + 1'b1 : fill;
    sout_nx = clr ? 1'b0 :
              op == MODE_SHR ? q[0] :
              op == MODE_SHL ? q[WIDTH-1] : sout;
  end
`ifdef SHIFT_REG_UNIV_NEGEDGE_EN
  always_ff @(negedge clk or negedge rst_n) begin
`else
  always_ff @(posedge clk or negedge rst_n) begin
`endif
    if (!rst_n) begin
      fill <= '0;
      sout <= 1'b0;
    end else begin
      fill <= fill_nx;
      sout <= sout_nx;
    end
  end
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: WIDTH-bit storage with hold, shift-right, shift-left and parallel-load modes, an optional rotate mode, a synchronous clear, and a saturating fill counter. It is the general-purpose successor to the single-bit D storage elements and is used wherever serial-to-parallel, parallel-to-serial or bit-stream capture is needed in lab datapaths. All state is edge-triggered on the single clock, with an asynchronous active-low reset.

## Interface
- WIDTH, default 8: number of storage bits, minimum 2.
- ROTATE, default 0:
  - 0: shifts take the incoming bit from `sin`.
  - 1: shifts wrap the outgoing bit and ignore `sin`.
- clk  input  1  the only clock; all state updates on its active edge (rising by default).
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enables the mode operation on the active edge.
- clr  input  1  synchronous clear; acts regardless of `en`.
- mode  input  2  operation select; uses the package `mode_t` type.
- sin  input  1  serial input bit.
- din  input  WIDTH  parallel load data.
- q  output  WIDTH  register contents.
- sout  output  1  registered copy of the last bit shifted out.
- fill  output  $clog2(WIDTH+1)  number of valid bits accumulated.
- full  output  1  high when `fill == WIDTH`.

## Operation
- Priority: `rst_n` low > `clr` > (`en` and `mode`) > hold.
- `mode` encodings:
  - MODE_HOLD (00): no change.
  - MODE_SHR (01):
    - q <= {sin, q[WIDTH-1:1]}.
    - sout <= q[0].
  - MODE_SHL (10):
    - q <= {q[WIDTH-2:0], sin}.
    - sout <= q[WIDTH-1].
  - MODE_LOAD (11):
    - q <= din.
    - fill <= WIDTH.
    - sout unchanged.
- ROTATE=1: the incoming bit is the outgoing bit (q[0] for SHR, q[WIDTH-1] for SHL). `sout` still captures that bit.
- fill:
  - Increments by 1 on each SHR/SHL and saturates at WIDTH; it never wraps.
  - Unchanged on HOLD or when `en` is low.
- `clr` high: q <= 0, fill <= 0, sout <= 0, whatever the values of `en` and `mode`.
- `en` low with `clr` low: all state holds, whatever the value of `mode`.

## Timing
- Reset:
  - `rst_n` low forces q=0, sout=0, fill=0, full=0 immediately, without waiting for a clock edge.
  - Release of `rst_n` is synchronous to the next active edge.
- Reset asserted mid-operation, including mid shift sequence: state is discarded and no partial update survives.
- Latency: every operation is visible on `q`/`sout`/`fill` one active edge after the inputs are sampled.
- `full` is combinational from the registered `fill`, so it follows `fill` in the same cycle.
- Inputs must be stable around the active edge; there are no level-sensitive (latch) paths.
- Back-to-back operations on consecutive edges are fully supported; there is no busy state.

## Configuration
- SHIFT_REG_UNIV_NEGEDGE_EN:
  - Defined: every register in the block updates on the falling edge of `clk`.
  - Undefined: every register updates on the rising edge of `clk`.
- In both cases reset stays asynchronous, active-low and edge-independent.
- The macro changes no functional behaviour other than which clock edge is active.

## Structure
- Package `shift_reg_univ_pkg` holds:
  - `typedef enum logic [1:0] mode_t` with MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD.
  - A function computing the `fill` width from WIDTH.
- Sub-module `usr_bit_cell`, instantiated WIDTH times through generate:
  - A 4:1 next-state mux (hold / left neighbour / right neighbour / load bit) feeding one resettable flop.
  - Honours the same edge macro.
- The fill counter, `sout` register and `clr`/`en` priority logic live in the top module.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Assert `rst_n` low between clock edges after loading 8'hFF → q=00, sout=0, fill=0, full=0 immediately, with no clock edge required.
- en=1, mode=LOAD, din=8'hA5 → after one edge q=A5, fill=8, full=1.
- From q=A5:
  - SHR with sin=1 → q=D2, sout=1.
  - Reload A5, then SHL with sin=0 → q=4A, sout=1.
- After reset, 9 consecutive SHR edges with sin=1 → fill steps 1..8, full rises on the 8th edge, q=FF, fill stays 8 on the 9th edge.
- ROTATE=1, load 8'h81, then SHL with sin=0 → q=03, sout=1; fill stays 8.
- en=0 with mode=LOAD and din=3C → no change. Then clr=1 with en=0 → q=00, fill=0, sout=0 on the next edge. Repeat the whole plan with SHIFT_REG_UNIV_NEGEDGE_EN defined and check updates occur only on falling edges.
